// File: rtl/axi_lite_master_if.sv
// AXI_LITE: 32-bit AXI-Lite bundle with master and slave views.
interface AXI_LITE;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;
  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding request/response port to AXI-Lite master with timeout abort.
module axi_lite_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic        busy,
  AXI_LITE.master     axi
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R} state_t;
  state_t state, state_d;
  logic aw_done, aw_done_d, w_done, w_done_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] resp_d;
  logic rsp_valid_d, rsp_timeout_d, aw_hs, w_hs, done, abort;
  assign req_ready    = state == IDLE;
  assign busy         = state != IDLE;
  assign axi.aw_valid = state == WR_ADDR_DATA && !aw_done;
  assign axi.w_valid  = state == WR_ADDR_DATA && !w_done;
  assign axi.b_ready  = state == WAIT_B;
  assign axi.ar_valid = state == RD_ADDR;
  assign axi.r_ready  = state == WAIT_R;
  assign axi.aw_addr  = addr_q;
  assign axi.ar_addr  = addr_q;
  assign axi.w_data   = wdata_q;
  assign axi.w_strb   = wstrb_q;
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;
  assign done  = (state == WAIT_B && axi.b_valid) || (state == WAIT_R && axi.r_valid);
  // A completing B/R handshake in the final budget cycle beats the abort.
  assign abort = TIMEOUT_CYCLES != 0 && busy && cnt == CW'(TIMEOUT_CYCLES) && !done;
  always_comb begin
    state_d       = state;
    aw_done_d     = aw_done;
    w_done_d      = w_done;
    cnt_d         = cnt;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = 1'b0;
    rdata_d       = rsp_rdata;
    resp_d        = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    case (state)
      IDLE: if (req_valid) begin
        addr_d    = req_addr;
        wdata_d   = req_wdata;
        wstrb_d   = req_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        cnt_d     = '0;
        state_d   = req_write ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done || aw_hs;
        w_done_d  = w_done || w_hs;
        state_d   = aw_done_d && w_done_d ? WAIT_B : WR_ADDR_DATA;
      end
      WAIT_B: if (axi.b_valid) begin
        state_d       = IDLE;
        rsp_valid_d   = 1'b1;
        rdata_d       = '0;
        resp_d        = axi.b_resp;
        rsp_timeout_d = 1'b0;
      end
      RD_ADDR: state_d = axi.ar_ready ? WAIT_R : RD_ADDR;
      WAIT_R: if (axi.r_valid) begin
        state_d       = IDLE;
        rsp_valid_d   = 1'b1;
        rdata_d       = axi.r_data;
        resp_d        = axi.r_resp;
        rsp_timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (busy && cnt != CW'(TIMEOUT_CYCLES)) cnt_d = cnt + CW'(1);
    if (abort) begin
      state_d       = IDLE;
      rsp_valid_d   = 1'b1;
      rdata_d       = '0;
      resp_d        = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      aw_done     <= aw_done_d;
      w_done      <= w_done_d;
      cnt         <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rdata_d;
      rsp_resp    <= resp_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed vectors against axi_lite_master with a hand-driven AXI-Lite slave.
module tb_axi_lite_master;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic rsp_valid, req_ready, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  int passed = 0, total = 0;
  AXI_LITE axi ();
  axi_lite_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy), .axi(axi)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic slave_idle();
    axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 0; axi.b_resp = 0;
    axi.ar_ready = 0; axi.r_valid = 0; axi.r_data = 0; axi.r_resp = 0;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    check("req_ready_before", req_ready, 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    tick();
    req_valid = 0;
  endtask
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    slave_idle();
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_valids", {axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready}, 0);
    check("rst_addr", axi.aw_addr | axi.ar_addr | axi.w_data, 0);
    check("rst_strb", axi.w_strb, 0);
    resetn = 1;
    tick();
    // zero-wait write
    axi.aw_ready = 1; axi.w_ready = 1;
    issue(1, 32'h0, 32'hA5, 4'b0001);
    check("w0_valids", {axi.aw_valid, axi.w_valid}, 2'b11);
    check("w0_wdata", axi.w_data, 32'hA5);
    check("w0_wstrb", axi.w_strb, 4'b0001);
    check("w0_busy", {busy, req_ready}, 2'b10);
    tick();
    check("w0_after_hs", {axi.aw_valid, axi.w_valid, axi.b_ready}, 3'b001);
    check("w0_no_rsp_n2", rsp_valid, 0);
    axi.b_valid = 1; axi.b_resp = 2'b00;
    tick();
    slave_idle();
    check("w0_rsp", {rsp_valid, rsp_timeout, rsp_resp, req_ready, axi.b_ready}, 6'b100010);
    check("w0_rdata", rsp_rdata, 0);
    tick();
    check("w0_pulse", rsp_valid, 0);
    // skewed write: AW at N+1, W at N+4, SLVERR response
    axi.aw_ready = 1;
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("ws_n1", {axi.aw_valid, axi.w_valid}, 2'b11);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("ws_aw_low", axi.aw_valid, 0);
      check("ws_w_high", axi.w_valid, 1);
      check("ws_wdata", axi.w_data, 32'hDEADBEEF);
      check("ws_b_low", axi.b_ready, 0);
      if (i == 4) axi.w_ready = 1;
    end
    tick();
    check("ws_n5", {axi.aw_valid, axi.w_valid, axi.b_ready}, 3'b001);
    axi.b_valid = 1; axi.b_resp = 2'b10;
    tick();
    slave_idle();
    check("ws_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1010);
    // read with R delayed 5 cycles
    axi.ar_ready = 1;
    issue(0, 32'h20, 32'h0, 4'h0);
    check("rd_ar", axi.ar_valid, 1);
    check("rd_araddr", axi.ar_addr, 32'h20);
    tick();
    axi.ar_ready = 0;
    check("rd_wait", {axi.ar_valid, axi.r_ready}, 2'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_no_rsp", {rsp_valid, axi.r_ready}, 2'b01);
    end
    axi.r_valid = 1; axi.r_data = 32'h12345678; axi.r_resp = 2'b00;
    tick();
    slave_idle();
    check("rd_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);
    check("rd_rdata", rsp_rdata, 32'h12345678);
    tick();
    check("rd_hold", {rsp_valid, rsp_rdata}, {1'b0, 32'h12345678});
    // unresponsive slave: abort after 16 counted cycles
    issue(0, 32'h30, 32'h0, 4'h0);
    for (int i = 0; i < 16; i++) tick();
    check("to_pre", {axi.ar_valid, rsp_valid}, 2'b10);
    tick();
    check("to_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1110);
    check("to_rdata", rsp_rdata, 0);
    check("to_drop", {axi.ar_valid, req_ready, busy}, 3'b010);
    // following request proceeds normally
    axi.aw_ready = 1; axi.w_ready = 1;
    issue(1, 32'h4, 32'h55, 4'h1);
    tick();
    axi.b_valid = 1;
    tick();
    slave_idle();
    check("after_to", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1000);
    // B arrives exactly in the abort cycle, DECERR passes through
    axi.aw_ready = 1; axi.w_ready = 1;
    issue(1, 32'hFFFF0000, 32'h1, 4'hF);
    tick();
    axi.aw_ready = 0; axi.w_ready = 0;
    for (int i = 0; i < 15; i++) tick();
    check("ab_b_ready", {axi.b_ready, rsp_valid}, 2'b10);
    axi.b_valid = 1; axi.b_resp = 2'b11;
    tick();
    slave_idle();
    check("ab_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 4'b1011);
    // reset while in WAIT_R
    axi.ar_ready = 1;
    issue(0, 32'h40, 32'h0, 4'h0);
    tick();
    check("rr_wait_r", axi.r_ready, 1);
    #2 resetn = 0; axi.r_valid = 1; axi.r_data = 32'hCAFE;
    #1;
    check("rr_drop", {axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready, busy}, 0);
    tick();
    check("rr_no_rsp", rsp_valid, 0);
    slave_idle();
    resetn = 1;
    tick();
    check("rr_ready", {req_ready, rsp_valid}, 2'b10);
    check("rr_rdata", rsp_rdata, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
